// File: rtl/dataflow_fifo_pkg.sv
// ---------------------------------------------------------------------------
// dataflow_fifo_pkg
// Shared definitions for the dataflow start/stream FIFOs:
//   - read-pointer empty encoding (all-ones, i.e. -1)
//   - flag values taken on reset
//   - per-cycle operation encoding {push, pop}
//   - clog2 helper used by elaboration-time parameter checks
// ---------------------------------------------------------------------------
package dataflow_fifo_pkg;

    // Empty read pointer is -1; cast to the pointer width at the use site.
    localparam int PTR_EMPTY_VAL = -1;

    // Flag values while reset is asserted.
    localparam logic FULL_N_RST  = 1'b1;
    localparam logic EMPTY_N_RST = 1'b0;

    // One-cycle operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Smallest w with 2**w >= n (returns 0 for n <= 1).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : dataflow_fifo_pkg

// File: rtl/dataflow_start_srl_store.sv
// ---------------------------------------------------------------------------
// dataflow_start_srl_store
// DATA_WIDTH x DEPTH shift-register array. On we, every entry moves up one
// slot and din enters slot 0. dout is a combinational read of slot addr.
// Ports:
//   clk   in   clock
//   we    in   shift enable
//   addr  in   read address (ADDR_WIDTH bits)
//   din   in   data entering slot 0
//   dout  out  contents of slot addr ('0 when addr is beyond DEPTH-1)
// ---------------------------------------------------------------------------
module dataflow_start_srl_store #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto shift-register
    // primitives; which entries are meaningful is decided by the read pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= din;
        end
    end

    // The empty pointer (all-ones) can address past DEPTH-1 when DEPTH is
    // not a power of two; return zero there instead of indexing off the end.
    always_comb begin
        // NOTE: default first so the guarded read cannot infer a latch.
        dout = '0;
        if (int'(addr) < DEPTH) begin
            dout = mem[addr];
        end
    end

endmodule : dataflow_start_srl_store

// File: rtl/dataflow_start_srl_fifo.sv
// ---------------------------------------------------------------------------
// dataflow_start_srl_fifo
// First-word-fall-through FIFO on a shift-register store. New data enters
// slot 0 and ages upward; a read pointer tracks the oldest entry.
// Ports:
//   ap_clk       in   clock, rising edge
//   ap_rst_n     in   asynchronous active-low reset
//   if_write_ce  in   write clock-enable
//   if_write     in   write request
//   if_din       in   write data
//   if_full_n    out  registered, 1 = space available
//   if_read_ce   in   read clock-enable
//   if_read      in   read acknowledge of current if_dout
//   if_dout      out  oldest entry (valid when if_empty_n = 1)
//   if_empty_n   out  registered, 1 = data available
//   occupancy    out  registered entry count 0..DEPTH
// ---------------------------------------------------------------------------
module dataflow_start_srl_fifo
    import dataflow_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam int PW = ADDR_WIDTH + 1;

    // Pointer value that, on a push, makes the FIFO full. For DEPTH=1 this is
    // -1, identical to the empty encoding, so the first push fills it.
    localparam logic [ADDR_WIDTH:0] PTR_LAST_FREE = PW'(DEPTH - 2);
    localparam logic [ADDR_WIDTH:0] PTR_EMPTY     = PW'(PTR_EMPTY_VAL);

    if (ADDR_WIDTH < 1 || DEPTH < 1 || ADDR_WIDTH < clog2(DEPTH)) begin : g_bad_params
        $error("dataflow_start_srl_fifo: need DEPTH >= 1 and 2**ADDR_WIDTH >= DEPTH");
    end

    logic                push;
    logic                pop;
    fifo_op_e            op;
    logic [ADDR_WIDTH:0] ptr;

    // Qualifiers use only registered flags, so there is no combinational
    // path from if_read/if_write back to if_full_n/if_empty_n.
    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n;
    assign op   = fifo_op_e'({push, pop});

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr        <= PTR_EMPTY;
            if_full_n  <= FULL_N_RST;
            if_empty_n <= EMPTY_N_RST;
            occupancy  <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    ptr        <= ptr + PW'(1);
                    occupancy  <= occupancy + PW'(1);
                    if_empty_n <= 1'b1;
                    if (ptr == PTR_LAST_FREE) begin
                        if_full_n <= 1'b0;
                    end
                end
                OP_POP: begin
                    ptr       <= ptr - PW'(1);
                    occupancy <= occupancy - PW'(1);
                    if_full_n <= 1'b1;
                    if (ptr == '0) begin
                        if_empty_n <= 1'b0;
                    end
                end
                // Idle, or push+pop: count and flags hold; the store still
                // shifts on the push, which moves the oldest entry under ptr.
                default: ;
            endcase
        end
    end

    dataflow_start_srl_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_store (
        .clk  (ap_clk),
        .we   (push),
        .addr (ptr[ADDR_WIDTH-1:0]),
        .din  (if_din),
        .dout (if_dout)
    );

endmodule : dataflow_start_srl_fifo

// File: tb/tb_dataflow_start_srl_fifo.sv
// ---------------------------------------------------------------------------
// tb_dataflow_start_srl_fifo
// Three FIFO instances (DEPTH 4, 2, 1). Stimulus pushes expected read data
// into per-instance queues; monitors compare if_dout on every accepted read.
// Flags and occupancy are checked directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_dataflow_start_srl_fifo;

    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DEPTH=4 instance
    logic       wce4, wr4, rce4, rd4, full_n4, empty_n4;
    logic [3:0] din4, dout4;
    logic [2:0] occ4;
    // DEPTH=2 instance
    logic       wce2, wr2, rce2, rd2, full_n2, empty_n2;
    logic [3:0] din2, dout2;
    logic [1:0] occ2;
    // DEPTH=1 instance
    logic       wce1, wr1, rce1, rd1, full_n1, empty_n1;
    logic [3:0] din1, dout1;
    logic [1:0] occ1;

    dataflow_start_srl_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .DEPTH(4)) u_fifo4 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write_ce(wce4), .if_write(wr4), .if_din(din4), .if_full_n(full_n4),
        .if_read_ce(rce4), .if_read(rd4), .if_dout(dout4), .if_empty_n(empty_n4),
        .occupancy(occ4)
    );

    dataflow_start_srl_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(1), .DEPTH(2)) u_fifo2 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write_ce(wce2), .if_write(wr2), .if_din(din2), .if_full_n(full_n2),
        .if_read_ce(rce2), .if_read(rd2), .if_dout(dout2), .if_empty_n(empty_n2),
        .occupancy(occ2)
    );

    dataflow_start_srl_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(1), .DEPTH(1)) u_fifo1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write_ce(wce1), .if_write(wr1), .if_din(din1), .if_full_n(full_n1),
        .if_read_ce(rce1), .if_read(rd1), .if_dout(dout1), .if_empty_n(empty_n1),
        .occupancy(occ1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] q4[$];
    logic [3:0] q2[$];
    logic [3:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare read data on each accepted read, mid-cycle.
    always @(negedge clk) begin
        if (rst_n && rd4 && rce4 && empty_n4) begin
            if (q4.size() == 0) check("u4_read_without_expected", q4.size(), 1);
            else begin
                check("u4_dout", dout4, q4[0]);
                void'(q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd2 && rce2 && empty_n2) begin
            if (q2.size() == 0) check("u2_read_without_expected", q2.size(), 1);
            else begin
                check("u2_dout", dout2, q2[0]);
                void'(q2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd1 && rce1 && empty_n1) begin
            if (q1.size() == 0) check("u1_read_without_expected", q1.size(), 1);
            else begin
                check("u1_dout", dout1, q1[0]);
                void'(q1.pop_front());
            end
        end
    end

    initial begin
        {wce4, wr4, rce4, rd4, din4} = '0;
        {wce2, wr2, rce2, rd2, din2} = '0;
        {wce1, wr1, rce1, rd1, din1} = '0;
        rst_n = 1'b0;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 3; i++) begin
            {wce4, wr4, rce4, rd4} = 4'($urandom_range(0, 15));
            din4 = 4'($urandom_range(0, 15));
            tick();
        end
        check("rst_full_n", full_n4, 1);
        check("rst_empty_n", empty_n4, 0);
        check("rst_occ", occ4, 0);
        check("rst_u2_full_n", full_n2, 1);
        check("rst_u1_empty_n", empty_n1, 0);
        {wce4, wr4, rce4, rd4, din4} = '0;
        rst_n = 1'b1;
        tick();

        // ---------------- DEPTH=4 fill ----------------
        wce4 = 1'b1; wr4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din4 = 4'(4'hA + i);
            q4.push_back(din4);
            tick();
            check("fill_occ", occ4, i + 1);
            check("fill_empty_n", empty_n4, 1);
        end
        check("fill_full_n", full_n4, 0);
        din4 = 4'hE;          // write while full: must be dropped
        tick();
        check("full_write_occ", occ4, 4);
        check("full_write_full_n", full_n4, 0);
        wr4 = 1'b0;

        // ---------------- DEPTH=4 drain ----------------
        rce4 = 1'b1; rd4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_occ", occ4, 3 - i);
            check("drain_full_n", full_n4, 1);
        end
        check("drain_empty_n", empty_n4, 0);
        rd4 = 1'b0;
        tick();
        check("empty_read_occ", occ4, 0);

        // ---------------- simultaneous push/pop at occupancy 2 ----------------
        wr4 = 1'b1;
        din4 = 4'hA; q4.push_back(din4); tick();
        din4 = 4'hB; q4.push_back(din4); tick();
        check("pre_both_occ", occ4, 2);
        din4 = 4'hC; q4.push_back(din4); rd4 = 1'b1;
        tick();
        check("both_occ", occ4, 2);
        check("both_dout", dout4, 4'hB);
        check("both_full_n", full_n4, 1);
        check("both_empty_n", empty_n4, 1);
        wr4 = 1'b0;
        tick(); tick();
        check("both_drained_empty_n", empty_n4, 0);
        rd4 = 1'b0;

        // ---------------- CE gating ----------------
        wr4 = 1'b1; din4 = 4'h5; q4.push_back(din4);
        tick();
        wce4 = 1'b0; rce4 = 1'b0; rd4 = 1'b1; din4 = 4'h6;
        for (int i = 0; i < 5; i++) tick();
        check("ce_occ", occ4, 1);
        check("ce_dout", dout4, 4'h5);
        check("ce_full_n", full_n4, 1);
        check("ce_empty_n", empty_n4, 1);
        wr4 = 1'b0; rce4 = 1'b1; wce4 = 1'b1;
        tick();
        rd4 = 1'b0;
        check("ce_after_read_occ", occ4, 0);

        // ---------------- asynchronous reset mid-stream ----------------
        wr4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din4 = 4'(4'h7 + i); q4.push_back(din4); tick();
        end
        wr4 = 1'b0;
        check("pre_rst_occ", occ4, 3);
        #1 rst_n = 1'b0;
        q4.delete();
        #1;  // well before the next edge
        check("async_rst_occ", occ4, 0);
        check("async_rst_empty_n", empty_n4, 0);
        check("async_rst_full_n", full_n4, 1);
        tick();
        rst_n = 1'b1;
        tick();
        wr4 = 1'b1; din4 = 4'h3; q4.push_back(din4);
        tick();
        wr4 = 1'b0; rd4 = 1'b1;
        tick();
        rd4 = 1'b0;
        check("post_rst_occ", occ4, 0);

        // ---------------- DEPTH=2 full with read and write ----------------
        wce2 = 1'b1; rce2 = 1'b1; wr2 = 1'b1;
        din2 = 4'h1; q2.push_back(din2); tick();
        check("d2_half_full_n", full_n2, 1);
        din2 = 4'h2; q2.push_back(din2); tick();
        check("d2_full_n", full_n2, 0);
        check("d2_full_occ", occ2, 2);
        din2 = 4'h3; rd2 = 1'b1;      // only the pop is accepted
        tick();
        check("d2_rw_occ", occ2, 1);
        check("d2_rw_full_n", full_n2, 1);
        check("d2_rw_dout", dout2, 4'h2);
        wr2 = 1'b0;
        tick();
        rd2 = 1'b0;
        check("d2_empty_n", empty_n2, 0);

        // ---------------- DEPTH=1 ----------------
        wce1 = 1'b1; rce1 = 1'b1; wr1 = 1'b1;
        din1 = 4'h6; q1.push_back(din1);
        tick();
        check("d1_full_n", full_n1, 0);
        check("d1_empty_n", empty_n1, 1);
        check("d1_occ", occ1, 1);
        din1 = 4'h7; rd1 = 1'b1;      // full: only the pop is accepted
        tick();
        check("d1_rw_full_n", full_n1, 1);
        check("d1_rw_empty_n", empty_n1, 0);
        rd1 = 1'b0; q1.push_back(din1);
        tick();
        wr1 = 1'b0;
        check("d1_refill_full_n", full_n1, 0);
        check("d1_refill_dout", dout1, 4'h7);
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        check("d1_final_occ", occ1, 0);

        tick();
        check("q4_all_read", q4.size(), 0);
        check("q2_all_read", q2.size(), 0);
        check("q1_all_read", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dataflow_start_srl_fifo
